// File: rtl/axi4_lite_set_check_pkg.sv
// Shared constants and helpers for the AXI4-Lite set/check register block.
package axi4_lite_set_check_pkg;

  // Byte offsets of the mapped registers.
  localparam logic [7:0] ADDR_SET_OUT   = 8'h00;
  localparam logic [7:0] ADDR_CHECK_IN  = 8'h04;
  localparam logic [7:0] ADDR_CHECK_EXP = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h0C;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // STATUS register bit positions.
  localparam int unsigned STATUS_MATCH_BIT  = 0;
  localparam int unsigned STATUS_STICKY_BIT = 1;

  typedef enum logic [2:0] {
    SelSetOut,
    SelCheckIn,
    SelCheckExp,
    SelStatus,
    SelNone
  } reg_sel_e;

  // Expand 4 byte strobes into a 32-bit bit-enable mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/level_sync2.sv
// Two-flop level synchronizer for quasi-static asynchronous inputs.
module level_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/axi4_lite_set_check_regs.sv
// AXI4-Lite slave that drives set_o levels and compares synchronized check_i
// levels against an expected value, with a sticky mismatch flag.
module axi4_lite_set_check_regs
  import axi4_lite_set_check_pkg::*;
#(
  parameter int unsigned           SET_WIDTH   = 32,
  parameter int unsigned           CHECK_WIDTH = 32,
  parameter logic [SET_WIDTH-1:0]  SET_INIT    = '0,
  parameter int unsigned           ADDR_WIDTH  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_WIDTH-1:0]  s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [SET_WIDTH-1:0]   set_o,
  input  logic [CHECK_WIDTH-1:0] check_i,
  output logic                   match_o
);

  logic                   aw_ready_q, aw_ready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   ar_ready_q, ar_ready_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SET_WIDTH-1:0]   set_q, set_d;
  logic [CHECK_WIDTH-1:0] exp_q, exp_d;
  logic                   sticky_q, sticky_d;

  logic [CHECK_WIDTH-1:0] check_sync;
  logic                   match;
  logic                   wr_fire, rd_fire;
  reg_sel_e               wr_sel, rd_sel;
  logic [31:0]            wmask, set_merged, exp_merged;

  // Byte offset bits never take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] base;
    base = {addr[ADDR_WIDTH-1:2], 2'b00};
    if (base == ADDR_WIDTH'(ADDR_SET_OUT))        return SelSetOut;
    else if (base == ADDR_WIDTH'(ADDR_CHECK_IN))  return SelCheckIn;
    else if (base == ADDR_WIDTH'(ADDR_CHECK_EXP)) return SelCheckExp;
    else if (base == ADDR_WIDTH'(ADDR_STATUS))    return SelStatus;
    else                                          return SelNone;
  endfunction

  level_sync2 #(
    .WIDTH (CHECK_WIDTH)
  ) u_check_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (check_i),
    .q     (check_sync)
  );

  assign match   = (check_sync == exp_q);
  assign wr_fire = aw_ready_q & s_awvalid & s_wvalid;
  assign rd_fire = ar_ready_q & s_arvalid;
  assign wr_sel  = decode(s_awaddr);
  assign rd_sel  = decode(s_araddr);
  assign wmask   = strb_to_mask(s_wstrb);

  assign set_merged = (32'(set_q) & ~wmask) | (s_wdata & wmask);
  assign exp_merged = (32'(exp_q) & ~wmask) | (s_wdata & wmask);

  // Next-state for handshakes, registers and read data.
  always_comb begin
    aw_ready_d = s_awvalid && s_wvalid && !aw_ready_q && !bvalid_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ar_ready_d = s_arvalid && !ar_ready_q && !rvalid_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    set_d      = set_q;
    exp_d      = exp_q;
    sticky_d   = sticky_q;

    // Write channel: update on the accept edge, respond the cycle after.
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_sel == SelNone) ? RESP_SLVERR : RESP_OKAY;
      case (wr_sel)
        SelSetOut:   set_d = set_merged[SET_WIDTH-1:0];
        SelCheckExp: exp_d = exp_merged[CHECK_WIDTH-1:0];
        default:     ;
      endcase
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end

    // Mismatch beats a simultaneous clear so no miss is ever lost.
    if (!match) begin
      sticky_d = 1'b1;
    end else if (wr_fire && (wr_sel == SelStatus) && s_wstrb[0] &&
                 s_wdata[STATUS_STICKY_BIT]) begin
      sticky_d = 1'b0;
    end

    // Read channel: sample current register state on the accept edge.
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (rd_sel)
        SelSetOut:   rdata_d = 32'(set_q);
        SelCheckIn:  rdata_d = 32'(check_sync);
        SelCheckExp: rdata_d = 32'(exp_q);
        SelStatus: begin
          rdata_d[STATUS_MATCH_BIT]  = match;
          rdata_d[STATUS_STICKY_BIT] = sticky_q;
        end
        default:     rresp_d = RESP_SLVERR;
      endcase
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      set_q      <= SET_INIT;
      exp_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      aw_ready_q <= aw_ready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      set_q      <= set_d;
      exp_q      <= exp_d;
      sticky_q   <= sticky_d;
    end
  end

  assign s_awready = aw_ready_q;
  assign s_wready  = aw_ready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = ar_ready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign set_o     = set_q;
  assign match_o   = match;

endmodule

// File: tb/tb_axi4_lite_set_check_regs.sv
// Randomized scoreboard bench for axi4_lite_set_check_regs.
module tb_axi4_lite_set_check_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [4:0]  s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic [31:0] set_o;
  logic [31:0] check_i = '0;
  logic        match_o;

  axi4_lite_set_check_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .set_o     (set_o),
    .check_i   (check_i),
    .match_o   (match_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_b   = 1'b0;
  bit hold_r   = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endfunction

  // Reference model: register contents as the spec describes them.
  logic [31:0] m_set, m_exp, m_s1, m_s2;
  bit          m_sticky;
  logic [33:0] rq[$];  // {rresp, rdata}
  logic [1:0]  bq[$];

  function automatic logic [33:0] model_read(input logic [4:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    d = '0;
    r = 2'b00;
    case (a[4:2])
      3'd0: d = m_set;
      3'd1: d = m_s2;
      3'd2: d = m_exp;
      3'd3: d = {30'd0, m_sticky, (m_s2 == m_exp)};
      default: r = 2'b10;
    endcase
    return {r, d};
  endfunction

  // Model step: observe handshakes mid-cycle, predict the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_set = '0; m_exp = '0; m_s1 = '0; m_s2 = '0; m_sticky = 1'b0;
      rq.delete();
      bq.delete();
    end else begin
      bit mm;
      mm = (m_s2 != m_exp);
      check("match_o", {31'd0, match_o}, {31'd0, !mm});
      check("set_o", set_o, m_set);
      if (s_arvalid && s_arready) rq.push_back(model_read(s_araddr));
      if (mm) m_sticky = 1'b1;
      if (s_awvalid && s_wvalid && s_awready) begin
        check("wready_with_awready", {31'd0, s_wready}, 32'd1);
        if (!mm && s_awaddr[4:2] == 3'd3 && s_wstrb[0] && s_wdata[1]) m_sticky = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (s_wstrb[i]) begin
            if (s_awaddr[4:2] == 3'd0) m_set[8*i +: 8] = s_wdata[8*i +: 8];
            if (s_awaddr[4:2] == 3'd2) m_exp[8*i +: 8] = s_wdata[8*i +: 8];
          end
        end
        bq.push_back(s_awaddr[4:2] >= 3'd4 ? 2'b10 : 2'b00);
      end
      m_s2 = m_s1;
      m_s1 = check_i;
    end
  end

  // Monitor: compare each response as it is handed over.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_bvalid && s_bready) begin
        if (bq.size() == 0) check("spurious_bvalid", 32'd1, 32'd0);
        else check("bresp", {30'd0, s_bresp}, {30'd0, bq.pop_front()});
      end
      if (s_rvalid && s_rready) begin
        if (rq.size() == 0) begin
          check("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          logic [33:0] e;
          e = rq.pop_front();
          check("rdata", s_rdata, e[31:0]);
          check("rresp", {30'd0, s_rresp}, {30'd0, e[33:32]});
        end
      end
    end
  end

  // Random back-pressure on the response channels.
  always @(posedge clk) begin
    #1;
    s_bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
    s_rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_awready && n < 200);
    if (!s_awready) fail_now("write_accept");
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    wait_wr();
  endtask

  task automatic rd(input logic [4:0] a);
    int n;
    s_araddr  = a;
    s_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_arready && n < 200);
    if (!s_arready) fail_now("read_accept");
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (bq.size() != 0 || rq.size() != 0) fail_now("response_drain");
  endtask

  initial begin
    logic [31:0] pats[4];
    pats[0] = 32'h0000_00C3; pats[1] = 32'h0000_00C2;
    pats[2] = 32'h0000_005A; pats[3] = 32'h0000_0000;

    idle(3);
    rst_n = 1'b1;
    check("rst_set_o", set_o, 32'd0);
    check("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
    check("rst_awready", {31'd0, s_awready}, 32'd0);
    check("rst_arready", {31'd0, s_arready}, 32'd0);
    idle(3);
    rd(5'h0C);

    wr(5'h00, 32'hA5A5_1234, 4'hF);
    check("set_full", set_o, 32'hA5A5_1234);
    wr(5'h00, 32'hFFFF_FFFF, 4'h1);
    check("set_strb", set_o, 32'hA5A5_12FF);

    check_i = 32'h0000_00C3;
    wr(5'h08, 32'h0000_00C3, 4'hF);
    idle(3);
    check("match_c3", {31'd0, match_o}, 32'd1);
    rd(5'h04);
    wr(5'h0C, 32'h2, 4'h1);
    idle(1);
    rd(5'h0C);
    check_i = 32'h0000_00C2;
    idle(1);
    check_i = 32'h0000_00C3;
    idle(4);
    rd(5'h0C);
    wr(5'h0C, 32'h2, 4'h1);
    rd(5'h0C);
    rd(5'h14);
    wr(5'h18, 32'hDEAD_BEEF, 4'hF);
    drain();

    // Response stalled: second write must wait.
    hold_b = 1'b1;
    wr(5'h00, 32'h1111_1111, 4'hF);
    s_awaddr = 5'h00; s_wdata = 32'h2222_2222; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bvalid_held", {31'd0, s_bvalid}, 32'd1);
      check("aw_blocked", {31'd0, s_awready}, 32'd0);
    end
    @(posedge clk);
    #1;
    hold_b = 1'b0;
    wait_wr();
    check("second_write", set_o, 32'h2222_2222);
    drain();

    // Random traffic.
    for (int it = 0; it < 300; it++) begin
      logic [4:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0) check_i = pats[$urandom_range(0, 3)];
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      if (a[4:2] == 3'd2 && $urandom_range(0, 1) == 1) d = pats[$urandom_range(0, 3)];
      if (a[4:2] == 3'd3) d = {30'd0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) wr(a, d, 4'($urandom_range(0, 15)));
      else rd(a);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset in the middle of a pending read response.
    hold_r = 1'b1;
    wr(5'h00, 32'h0BAD_F00D, 4'hF);
    rd(5'h00);
    check("rvalid_pending", {31'd0, s_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_rvalid", {31'd0, s_rvalid}, 32'd0);
    check("rst_drops_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("rst_set_init", set_o, 32'd0);
    hold_r = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    rd(5'h00);
    rd(5'h0C);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
